// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU loader and operation stage.
//   N_MAX    : maximum matrix dimension
//   W        : element width (signed two's complement)
//   MAT_BITS : flattened operand width
//   idx(r,c) : bit offset of element (r,c) in a flattened operand (MSB at the offset)
package mpu_pkg;

    localparam int unsigned N_MAX    = 5;
    localparam int unsigned W        = 8;
    localparam int unsigned MAT_BITS = W * N_MAX * N_MAX;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned SIZE_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic TGT_A = 1'b0;
    localparam logic TGT_B = 1'b1;

    // Load request latched when start is accepted.
    typedef struct packed {
        logic             tgt;
        logic [CNT_W-1:0] n;
    } load_cfg_t;

    function automatic int unsigned idx(input int unsigned r, input int unsigned c);
        return W * (N_MAX * r + c);
    endfunction

endpackage

// File: rtl/mpu_index_counter.sv
// Row/column walker over an n x n block in row-major order.
//   clock, reset : clock, async active-high reset
//   clear        : return to (0,0)
//   advance      : step to the next position (col wraps at n-1, row then increments)
//   n            : active dimension
//   row, col     : current position
//   last_c       : current position is (n-1, n-1)
module mpu_index_counter
    import mpu_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] n,
    output logic [CNT_W-1:0] row,
    output logic [CNT_W-1:0] col,
    output logic             last_c
);

    logic [CNT_W-1:0] n_m1;

    assign n_m1   = n - CNT_W'(1);
    assign last_c = (row == n_m1) && (col == n_m1);

    // Position registers; clear has priority over advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == n_m1) begin
                col <= '0;
                row <= row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mpu_matrix_loader.sv
// Serial loader for the MPU operand registers.
// Receives row-major signed elements over a valid/ready stream and assembles
// them into matrix_a or matrix_b, zero-padding outside the active n x n block.
//   clock, reset       : clock, async active-high reset
//   start/target/size  : load request (target 0 = A, 1 = B; size 1..N_MAX)
//   in_data/in_valid   : element stream; in_ready is registered
//   matrix_a/matrix_b  : flattened operands, element k at [8k:8k+7], 8k = MSB
//   size_out           : dimension of last completed load
//   busy/done/error    : loading / load-complete pulse / illegal-size pulse
module mpu_matrix_loader
    import mpu_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                target,
    input  logic [SIZE_W-1:0]   size,
    input  logic [W-1:0]        in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [0:MAT_BITS-1] matrix_a,
    output logic [0:MAT_BITS-1] matrix_b,
    output logic [SIZE_W-1:0]   size_out,
    output logic                busy,
    output logic                done,
    output logic                error
);

    state_t           state;
    state_t           state_next;
    load_cfg_t        cfg;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
    logic             last_c;
    logic             legal_c;
    logic             load_start_c;
    logic             bad_start_c;
    logic             accept_c;
    int unsigned      base_c;

    assign legal_c      = (size != '0) && (size <= SIZE_W'(N_MAX));
    assign load_start_c = (state == IDLE) && start && legal_c;
    assign bad_start_c  = (state == IDLE) && start && !legal_c;
    // in_ready is high exactly while in LOAD, so this is the handshake.
    assign accept_c     = in_ready && in_valid;
    assign base_c       = idx(32'(row), 32'(col));

    mpu_index_counter u_index_counter (
        .clock   (clock),
        .reset   (reset),
        .clear   (load_start_c),
        .advance (accept_c),
        .n       (cfg.n),
        .row     (row),
        .col     (col),
        .last_c  (last_c)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_start_c)        state_next = LOAD;
            LOAD:    if (accept_c && last_c)  state_next = DONE;
            DONE:                             state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // Registered status outputs, operand storage and request latch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            size_out <= '0;
            matrix_a <= '0;
            matrix_b <= '0;
            cfg      <= '0;
        end else begin
            in_ready <= (state_next == LOAD);
            busy     <= (state_next == LOAD);
            done     <= (state_next == DONE);
            error    <= bad_start_c;

            // Whole target operand is cleared so positions outside n x n read zero.
            if (load_start_c) begin
                cfg.tgt <= target;
                cfg.n   <= CNT_W'(size);
                if (target == TGT_A) begin
                    matrix_a <= '0;
                end else begin
                    matrix_b <= '0;
                end
            end

            if (accept_c) begin
                if (cfg.tgt == TGT_A) begin
                    matrix_a[base_c +: W] <= in_data;
                end else begin
                    matrix_b[base_c +: W] <= in_data;
                end
                if (last_c) begin
                    size_out <= SIZE_W'(cfg.n);
                end
            end
        end
    end

endmodule

// File: doc/mpu_matrix_loader.md
Name: mpu_matrix_loader

Overview:
- Upstream feeder for the MPU operation stage.
- Receives signed 8-bit matrix elements serially over a valid/ready byte stream, in row-major order.
- Assembles them into the flattened 5x5 operand registers matrix_a or matrix_b and zero-pads every position outside the active size x size region.
- Holds both operands stable for the operation stage and reports the loaded dimension.

Parameters:
- N_MAX, 5, maximum matrix dimension (elements per row/column).
- W, 8, element width in bits (signed two's complement).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin loading a matrix.
- target  in  1  sampled with start: 0 = matrix_a, 1 = matrix_b.
- size  in  8  sampled with start: dimension n; legal values 1..N_MAX.
- in_data  in  W  signed element, row-major order.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts an element this cycle.
- matrix_a  out  W*N_MAX*N_MAX  operand A, same flattening as the operation stage: declared ascending 0..199, element k = 5*r + c occupies indices 8k..8k+7, index 8k is the element MSB.
- matrix_b  out  W*N_MAX*N_MAX  operand B, same layout.
- size_out  out  8  dimension of the most recent successful load.
- busy  out  1  high while in LOAD.
- done  out  1  one-cycle pulse when the last element has been written.
- error  out  1  one-cycle pulse when start carries an illegal size.

Behaviour:
- Reset (asynchronous, takes effect immediately): matrix_a = 0, matrix_b = 0, size_out = 0, in_ready = 0, busy = 0, done = 0, error = 0, state = IDLE, row = col = 0. Reset during LOAD discards the partial matrix; both matrices read zero.
- IDLE:
  - start with 1 <= size <= N_MAX: latch target and n, clear the whole target matrix to zero on the same edge, row = col = 0, go to LOAD.
  - start with size = 0 or size > N_MAX: error pulses for 1 cycle on the next cycle; both matrices and size_out are unchanged; stay in IDLE.
- LOAD:
  - in_ready = 1, busy = 1.
  - Each cycle with in_valid && in_ready writes in_data to element 5*row + col of the target matrix.
  - col increments; when col = n-1, col wraps to 0 and row increments.
  - Accepting element (n-1, n-1) moves to DONE.
  - No element is written when in_valid = 0, and the counters hold.
  - start is ignored while in LOAD.
- DONE (1 cycle): done = 1, in_ready = 0, busy = 0, size_out = n; return to IDLE.
  - A start asserted in DONE is ignored. The earliest new start is the cycle after done.
- Latency:
  - n*n accepted elements; done rises the cycle after the final handshake.
  - With in_valid held high, done comes n*n + 1 cycles after start's edge.
- Timing rules:
  - in_ready is a registered output with no combinational path from in_valid.
  - Positions outside the n x n block stay zero; the consumer relies on this for size < 5.
  - The non-target matrix is never modified by a load.
  - Loading A then B leaves both valid simultaneously.
  - Elements are stored bit-exact, with no sign extension or saturation.
- Extra input: in_valid asserted in IDLE or DONE is not accepted; data is dropped and ready stays 0.

Decomposition:
- Shared package mpu_pkg holds:
  - constants N_MAX = 5, W = 8, MAT_BITS = 200;
  - element-offset function idx(r, c) = 8*(5r + c);
  - state enum {IDLE, LOAD, DONE};
  - target encoding TGT_A = 0, TGT_B = 1.
- mpu_pkg is shared with the operation stage.
- One sub-module is natural: mpu_index_counter, a row/col counter with wrap at n-1 and a last flag. It is reusable by a future result-streamer stage.
- The matrix write stays in the top module.

Test Plan:
- Reset, then start (target = 0, size = 2), stream 1, 2, 3, 4 with in_valid constant -> done on cycle 5 after start; matrix_a elements k0 = 1, k1 = 2, k5 = 3, k6 = 4, all others 0; size_out = 2; matrix_b = 0.
- Load B with size = 5, elements k - 12 (signed, -12..12) with in_valid toggled every other cycle -> matrix_b element k = k - 12 (element 0 = 0xF4); in_ready stays high during gaps; done after the 25th handshake; matrix_a unchanged from the previous load.
- start with size = 0, then size = 6 -> error pulses twice; busy stays 0; matrices and size_out unchanged.
- Preload matrix_a full (all 0x7F, size 5), then load A with size = 3 of all 0x01 -> 9 positions = 0x01, the other 16 = 0.
- Assert reset after 7 of 25 elements -> immediate in_ready = 0, busy = 0, matrix_a = 0, matrix_b = 0, size_out = 0; a subsequent full load succeeds normally.
- start pulsed mid-LOAD and in the DONE cycle, plus in_valid asserted in IDLE -> each is ignored; the element count is unaffected; no extra done pulse.
